// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle for the sequential ALU.
//   start, op, a, c : request side, driven by the requester (master)
//   busy, done      : progress/status, driven by the ALU (slave)
//   out, hi         : result low word / high word (MULU high, DIVU remainder)
//   zero, carry,
//   ovf, dz         : result flags
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] c;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             dz;

    modport master (
        output start, op, a, c,
        input  busy, done, out, hi, zero, carry, ovf, dz
    );

    modport slave (
        input  start, op, a, c,
        output busy, done, out, hi, zero, carry, ovf, dz
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with registered results and flags.
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SLT) and DIVU-by-zero finish one clock after the
// accepting edge. MULU (shift-add) and DIVU (restoring) run WIDTH iterations while busy=1.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears state and all outputs
//   bus : alu_seq_if slave modport (start/op/a/c in; busy/done/out/hi/flags out)
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpAnd  = 3'd2;
    localparam logic [2:0] OpOr   = 3'd3;
    localparam logic [2:0] OpXor  = 3'd4;
    localparam logic [2:0] OpSlt  = 3'd5;
    localparam logic [2:0] OpMulu = 3'd6;
    localparam logic [2:0] OpDivu = 3'd7;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e state_q, state_d;

    // Iteration registers. The op in flight is encoded by the state, the multiplier/dividend
    // lives in work_lo and the multiplicand/divisor in c_q.
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Visible results; only written when an op completes.
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    // Single-cycle datapath on the live inputs (used only at the accepting edge).
    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] sub_diff;
    logic           a_msb;
    logic           c_msb;
    logic           slt;

    assign add_sum  = {1'b0, bus.a} + {1'b0, bus.c};
    assign sub_diff = {1'b0, bus.a} - {1'b0, bus.c};
    assign a_msb    = bus.a[WIDTH-1];
    assign c_msb    = bus.c[WIDTH-1];
    assign slt      = $signed(bus.a) < $signed(bus.c);

    // Shift-add multiply step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole 2*WIDTH product right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt;
    logic [WIDTH-1:0] mul_lo_nxt;

    assign mul_sum    = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, c_q} : {(WIDTH + 1){1'b0}});
    assign mul_hi_nxt = mul_sum[WIDTH:1];
    assign mul_lo_nxt = {mul_sum[0], work_lo_q[WIDTH-1:1]};

    // Restoring divide step: shift the next dividend bit into the partial remainder and
    // subtract the divisor when it fits. The remainder stays below the divisor, so the
    // trial difference always fits in WIDTH bits when it is kept.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_trial;
    logic [WIDTH-1:0] div_hi_nxt;
    logic [WIDTH-1:0] div_lo_nxt;

    assign div_shift  = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_ge     = div_shift >= {1'b0, c_q};
    assign div_trial  = div_shift[WIDTH-1:0] - c_q;
    assign div_hi_nxt = div_ge ? div_trial : div_shift[WIDTH-1:0];
    assign div_lo_nxt = {work_lo_q[WIDTH-2:0], div_ge};

    logic cnt_last;
    assign cnt_last = cnt_q == CntW'(WIDTH - 1);

    // Result staging: finish loads the res_* values into the visible registers.
    logic             finish;
    logic [WIDTH-1:0] res_out;
    logic [WIDTH-1:0] res_hi;
    logic             res_carry;
    logic             res_ovf;
    logic             res_dz;

    always_comb begin
        state_d   = state_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        finish    = 1'b0;
        res_out   = '0;
        res_hi    = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        res_dz    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    c_d       = bus.c;
                    cnt_d     = '0;
                    work_hi_d = '0;
                    work_lo_d = bus.a;
                    finish    = 1'b1;
                    state_d   = StDone;
                    case (bus.op)
                        OpAdd: begin
                            res_out   = add_sum[WIDTH-1:0];
                            res_carry = add_sum[WIDTH];
                            res_ovf   = (a_msb == c_msb) && (add_sum[WIDTH-1] != a_msb);
                        end
                        OpSub: begin
                            res_out   = sub_diff[WIDTH-1:0];
                            res_carry = sub_diff[WIDTH];
                            res_ovf   = (a_msb != c_msb) && (sub_diff[WIDTH-1] != a_msb);
                        end
                        OpAnd: res_out = bus.a & bus.c;
                        OpOr:  res_out = bus.a | bus.c;
                        OpXor: res_out = bus.a ^ bus.c;
                        OpSlt: res_out = {{(WIDTH - 1){1'b0}}, slt};
                        OpMulu: begin
                            finish  = 1'b0;
                            state_d = StMul;
                        end
                        OpDivu: begin
                            if (bus.c == '0) begin
                                res_out = '1;
                                res_hi  = bus.a;
                                res_dz  = 1'b1;
                            end else begin
                                finish  = 1'b0;
                                state_d = StDiv;
                            end
                        end
                    endcase
                end
            end
            StMul: begin
                work_hi_d = mul_hi_nxt;
                work_lo_d = mul_lo_nxt;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_last) begin
                    finish  = 1'b1;
                    res_out = mul_lo_nxt;
                    res_hi  = mul_hi_nxt;
                    state_d = StDone;
                end
            end
            StDiv: begin
                work_hi_d = div_hi_nxt;
                work_lo_d = div_lo_nxt;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_last) begin
                    finish  = 1'b1;
                    res_out = div_lo_nxt;
                    res_hi  = div_hi_nxt;
                    state_d = StDone;
                end
            end
            StDone: begin
                // start is deliberately ignored here; the next op is taken in StIdle.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        if (finish) begin
            out_d   = res_out;
            hi_d    = res_hi;
            zero_d  = res_out == '0;
            carry_d = res_carry;
            ovf_d   = res_ovf;
            dz_d    = res_dz;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            work_hi_q <= '0;
            work_lo_q <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            hi_q      <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            hi_q      <= hi_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.busy  = (state_q == StMul) || (state_q == StDiv);
    assign bus.done  = state_q == StDone;
    assign bus.out   = out_q;
    assign bus.hi    = hi_q;
    assign bus.zero  = zero_q;
    assign bus.carry = carry_q;
    assign bus.ovf   = ovf_q;
    assign bus.dz    = dz_q;
endmodule
